traffic_phase_ctrl: RTL and testbench

//  Two-street traffic-light phase sequencer; generates the one-hot light codes street_a/street_b
//  (3'b100 red, 3'b010 yellow, 3'b001 green) consumed by the countdown/7-seg display path.

---
 rtl/traffic_phase_ctrl.sv | 206 ++++++++++++++++++++
 tb/tb_traffic_phase_ctrl.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/traffic_phase_ctrl.sv
// Two-street traffic-light phase sequencer.
// Owns the 1 s prescaler and the per-phase second timer, and drives one-hot
// R/Y/G light codes plus seconds-remaining for each street. A street's red time
// is always the other street's green + yellow, so the lights never conflict.
// Night mode (flash_mode) blinks both streets yellow; leaving it goes through a
// street-A yellow clearance before the normal cycle resumes.
module traffic_phase_ctrl #(
    parameter int unsigned TICK_DIV = 50_000_000,
    parameter int unsigned GREEN_S  = 25,
    parameter int unsigned YELLOW_S = 5
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enable,
    input  logic       flash_mode,
    output logic [2:0] street_a,
    output logic [2:0] street_b,
    output logic [5:0] remain_a,
    output logic [5:0] remain_b,
    output logic       tick_1hz,
    output logic       phase_start
);

    localparam int unsigned PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;

    localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);
    localparam logic [5:0]    GRN_LOAD  = 6'(GREEN_S - 1);
    localparam logic [5:0]    YEL_LOAD  = 6'(YELLOW_S - 1);
    localparam logic [5:0]    YEL_LEN   = 6'(YELLOW_S);

    localparam logic [2:0] LT_RED = 3'b100;
    localparam logic [2:0] LT_YEL = 3'b010;
    localparam logic [2:0] LT_GRN = 3'b001;
    localparam logic [2:0] LT_OFF = 3'b000;

    typedef enum logic [2:0] {
        A_GRN = 3'd0,
        A_YEL = 3'd1,
        B_GRN = 3'd2,
        B_YEL = 3'd3,
        FLASH = 3'd4
    } state_t;

    state_t        state_q, state_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [5:0]    sec_q, sec_d;
    logic [2:0]    street_a_q, street_a_d;
    logic [2:0]    street_b_q, street_b_d;
    logic [5:0]    remain_a_q, remain_a_d;
    logic [5:0]    remain_b_q, remain_b_d;
    logic          tick_1hz_q, tick_1hz_d;
    logic          phase_start_q, phase_start_d;
    logic          tick;
    logic          illegal;

    // Prescaler, phase timer and state transitions.
    always_comb begin
        tick    = enable && (presc_q == PRESC_MAX);
        presc_d = presc_q;
        if (enable) begin
            presc_d = tick ? '0 : presc_q + PW'(1);
        end

        state_d = state_q;
        sec_d   = sec_q;
        illegal = 1'b0;

        case (state_q)
            A_GRN, A_YEL, B_GRN, B_YEL: begin
                // flash_mode wins over a coincident phase expiry
                if (flash_mode) begin
                    state_d = FLASH;
                end else if (tick) begin
                    if (sec_q != '0) begin
                        sec_d = sec_q - 6'd1;
                    end else begin
                        case (state_q)
                            A_GRN: begin
                                state_d = A_YEL;
                                sec_d   = YEL_LOAD;
                            end
                            A_YEL: begin
                                state_d = B_GRN;
                                sec_d   = GRN_LOAD;
                            end
                            B_GRN: begin
                                state_d = B_YEL;
                                sec_d   = YEL_LOAD;
                            end
                            default: begin
                                state_d = A_GRN;
                                sec_d   = GRN_LOAD;
                            end
                        endcase
                    end
                end
            end
            FLASH: begin
                // leave night mode through a fresh A-yellow clearance
                if (!flash_mode) begin
                    state_d = A_YEL;
                    sec_d   = YEL_LOAD;
                    presc_d = '0;
                end
            end
            default: begin
                illegal = 1'b1;
                state_d = A_GRN;
                sec_d   = GRN_LOAD;
                presc_d = '0;
            end
        endcase
    end

    // Light codes and seconds-remaining decoded from the next state so they register in step with it.
    always_comb begin
        street_a_d    = LT_GRN;
        street_b_d    = LT_RED;
        remain_a_d    = sec_d;
        remain_b_d    = sec_d + YEL_LEN;
        tick_1hz_d    = tick;
        phase_start_d = (state_d != state_q) && !illegal;

        case (state_d)
            A_GRN: begin
                street_a_d = LT_GRN;
                street_b_d = LT_RED;
                remain_a_d = sec_d;
                remain_b_d = sec_d + YEL_LEN;
            end
            A_YEL: begin
                street_a_d = LT_YEL;
                street_b_d = LT_RED;
                remain_a_d = sec_d;
                remain_b_d = sec_d;
            end
            B_GRN: begin
                street_a_d = LT_RED;
                street_b_d = LT_GRN;
                remain_a_d = sec_d + YEL_LEN;
                remain_b_d = sec_d;
            end
            B_YEL: begin
                street_a_d = LT_RED;
                street_b_d = LT_YEL;
                remain_a_d = sec_d;
                remain_b_d = sec_d;
            end
            FLASH: begin
                remain_a_d = '0;
                remain_b_d = '0;
                if (state_q != FLASH) begin
                    street_a_d = LT_YEL;
                end else if (tick) begin
                    street_a_d = (street_a_q == LT_YEL) ? LT_OFF : LT_YEL;
                end else begin
                    street_a_d = street_a_q;
                end
                street_b_d = street_a_d;
            end
            default: begin
                street_a_d = LT_GRN;
                street_b_d = LT_RED;
                remain_a_d = GRN_LOAD;
                remain_b_d = GRN_LOAD + YEL_LEN;
            end
        endcase

        if (illegal) begin
            tick_1hz_d = 1'b0;
        end
    end

    // State and registered outputs; synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= A_GRN;
            presc_q       <= '0;
            sec_q         <= GRN_LOAD;
            street_a_q    <= LT_GRN;
            street_b_q    <= LT_RED;
            remain_a_q    <= GRN_LOAD;
            remain_b_q    <= GRN_LOAD + YEL_LEN;
            tick_1hz_q    <= 1'b0;
            phase_start_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            presc_q       <= presc_d;
            sec_q         <= sec_d;
            street_a_q    <= street_a_d;
            street_b_q    <= street_b_d;
            remain_a_q    <= remain_a_d;
            remain_b_q    <= remain_b_d;
            tick_1hz_q    <= tick_1hz_d;
            phase_start_q <= phase_start_d;
        end
    end

    assign street_a    = street_a_q;
    assign street_b    = street_b_q;
    assign remain_a    = remain_a_q;
    assign remain_b    = remain_b_q;
    assign tick_1hz    = tick_1hz_q;
    assign phase_start = phase_start_q;

endmodule

// File: tb/tb_traffic_phase_ctrl.sv
// Self-checking bench for traffic_phase_ctrl (TICK_DIV=4, GREEN_S=3, YELLOW_S=2).
// The reference model tracks phase index, seconds elapsed in the phase and clocks
// elapsed in the current second, and derives lights/remain from lookup tables.
module tb_traffic_phase_ctrl;

    localparam int TICK_DIV = 4;
    localparam int GREEN_S  = 3;
    localparam int YELLOW_S = 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       enable = 1'b1;
    logic       flash_mode = 1'b0;
    logic [2:0] street_a, street_b;
    logic [5:0] remain_a, remain_b;
    logic       tick_1hz, phase_start;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    traffic_phase_ctrl #(
        .TICK_DIV(TICK_DIV),
        .GREEN_S (GREEN_S),
        .YELLOW_S(YELLOW_S)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .flash_mode (flash_mode),
        .street_a   (street_a),
        .street_b   (street_b),
        .remain_a   (remain_a),
        .remain_b   (remain_b),
        .tick_1hz   (tick_1hz),
        .phase_start(phase_start)
    );

    logic [19:0] dut_vec;
    assign dut_vec = {street_a, street_b, remain_a, remain_b, tick_1hz, phase_start};

    // ---------------- reference model ----------------
    int         dur [4] = '{GREEN_S, YELLOW_S, GREEN_S, YELLOW_S};
    logic [2:0] la  [4] = '{3'b001, 3'b010, 3'b100, 3'b100};
    logic [2:0] lb  [4] = '{3'b100, 3'b100, 3'b001, 3'b010};

    int   m_cnt = 0, m_phase = 0, m_elapsed = 0;
    bit   m_flash = 0, m_blink = 0;
    logic [2:0] m_a = 3'b001, m_b = 3'b100;
    logic [5:0] m_ra = 6'd2, m_rb = 6'd4;
    logic m_tick = 1'b0, m_ps = 1'b0;

    task automatic model_step();
        int  prev_mode;
        int  r;
        bit  t;
        if (!rst_n) begin
            m_cnt = 0; m_phase = 0; m_elapsed = 0;
            m_flash = 0; m_blink = 0; m_tick = 1'b0; m_ps = 1'b0;
        end else begin
            prev_mode = m_flash ? 4 : m_phase;
            t = enable && (m_cnt == TICK_DIV - 1);
            if (enable) m_cnt = t ? 0 : m_cnt + 1;
            m_tick = t;
            if (m_flash) begin
                if (!flash_mode) begin
                    m_flash = 0; m_phase = 1; m_elapsed = 0; m_cnt = 0;
                end else if (t) begin
                    m_blink = !m_blink;
                end
            end else if (flash_mode) begin
                m_flash = 1; m_blink = 1;
            end else if (t) begin
                m_elapsed++;
                if (m_elapsed == dur[m_phase]) begin
                    m_phase = (m_phase + 1) % 4;
                    m_elapsed = 0;
                end
            end
            m_ps = ((m_flash ? 4 : m_phase) != prev_mode);
        end
        if (m_flash) begin
            m_a = m_blink ? 3'b010 : 3'b000;
            m_b = m_a;
            m_ra = '0; m_rb = '0;
        end else begin
            r = dur[m_phase] - m_elapsed - 1;
            m_a = la[m_phase];
            m_b = lb[m_phase];
            m_ra = 6'((m_phase == 2) ? r + YELLOW_S : r);
            m_rb = 6'((m_phase == 0) ? r + YELLOW_S : r);
        end
    endtask

    always @(posedge clk) model_step();

    function automatic logic [19:0] exp_vec();
        return {m_a, m_b, m_ra, m_rb, m_tick, m_ps};
    endfunction

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0; enable = 1'b1; flash_mode = 1'b0;
        repeat (2) begin
            @(negedge clk);
            n_tests++;
            if (dut_vec !== {3'b001, 3'b100, 6'd2, 6'd4, 1'b0, 1'b0}) begin
                n_fail++;
                $display("FAIL reset_values got=%h want=%h", dut_vec, {3'b001, 3'b100, 6'd2, 6'd4, 2'b00});
            end
        end
        rst_n = 1'b1;
    endtask

    task automatic test_first_phase();
        int n = 0;
        while (street_a !== 3'b010 && n < 100) begin
            @(negedge clk); n++;
            n_tests++;
            if (dut_vec !== exp_vec()) begin
                n_fail++; $display("FAIL first_phase_model got=%h want=%h", dut_vec, exp_vec());
            end
        end
        n_tests++;
        if (n != 12) begin
            n_fail++; $display("FAIL a_grn_length got=%0d want=12", n);
        end
        n_tests++;
        if ({remain_a, phase_start} !== {6'd1, 1'b1}) begin
            n_fail++; $display("FAIL a_yel_entry got ra=%0d ps=%b want ra=1 ps=1", remain_a, phase_start);
        end
    endtask

    task automatic test_normal_cycle();
        int         exp_len [4] = '{8, 12, 8, 12};
        logic [5:0] exp_lt  [4] = '{6'b100_001, 6'b100_010, 6'b001_100, 6'b010_100};
        int len = 0, k = 0, cyc = 0;
        while (k < 4 && cyc < 60) begin
            @(negedge clk); len++; cyc++;
            n_tests++;
            if (dut_vec !== exp_vec()) begin
                n_fail++; $display("FAIL cycle_model got=%h want=%h", dut_vec, exp_vec());
            end
            n_tests++;
            if (street_a !== 3'b100 && street_b !== 3'b100) begin
                n_fail++; $display("FAIL cycle_conflict got a=%b b=%b want one red", street_a, street_b);
            end
            if (phase_start === 1'b1) begin
                n_tests++;
                if (len != exp_len[k] || {street_a, street_b} !== exp_lt[k]) begin
                    n_fail++;
                    $display("FAIL phase_%0d got len=%0d lights=%b want len=%0d lights=%b",
                             k, len, {street_a, street_b}, exp_len[k], exp_lt[k]);
                end
                k++; len = 0;
            end
        end
        n_tests++;
        if (k != 4) begin
            n_fail++; $display("FAIL cycle_phase_count got=%0d want=4", k);
        end
    endtask

    task automatic test_enable_freeze();
        int n = 0, rem;
        logic [19:0] frozen;
        while (!(m_phase == 0 && m_elapsed == 1 && !m_flash) && n < 100) begin
            @(negedge clk); n++;
            n_tests++;
            if (dut_vec !== exp_vec()) begin
                n_fail++; $display("FAIL freeze_seek_model got=%h want=%h", dut_vec, exp_vec());
            end
        end
        rem = (dur[0] - m_elapsed - 1) * TICK_DIV + (TICK_DIV - 1 - m_cnt) + 1;
        frozen = {m_a, m_b, m_ra, m_rb, 2'b00};
        enable = 1'b0;
        repeat (10) begin
            @(negedge clk);
            n_tests++;
            if (dut_vec !== frozen) begin
                n_fail++; $display("FAIL freeze_hold got=%h want=%h", dut_vec, frozen);
            end
        end
        enable = 1'b1;
        n = 0;
        while (street_a !== 3'b010 && n < 100) begin
            @(negedge clk); n++;
            n_tests++;
            if (dut_vec !== exp_vec()) begin
                n_fail++; $display("FAIL freeze_resume_model got=%h want=%h", dut_vec, exp_vec());
            end
        end
        n_tests++;
        if (n != rem) begin
            n_fail++; $display("FAIL freeze_resume_len got=%0d want=%0d", n, rem);
        end
    endtask

    task automatic test_flash_on_expiry();
        int n = 0;
        while (!(m_phase == 0 && m_elapsed == GREEN_S - 1 && m_cnt == TICK_DIV - 1 && !m_flash) && n < 200) begin
            @(negedge clk); n++;
            n_tests++;
            if (dut_vec !== exp_vec()) begin
                n_fail++; $display("FAIL flash_seek_model got=%h want=%h", dut_vec, exp_vec());
            end
        end
        flash_mode = 1'b1;
        @(negedge clk);
        n_tests++;
        if ({street_a, street_b, phase_start} !== {3'b010, 3'b010, 1'b1}) begin
            n_fail++; $display("FAIL flash_entry got a=%b b=%b ps=%b want a=010 b=010 ps=1",
                               street_a, street_b, phase_start);
        end
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            n_tests++;
            if (dut_vec !== exp_vec()) begin
                n_fail++; $display("FAIL flash_model got=%h want=%h", dut_vec, exp_vec());
            end
            if (i == 4 || i == 8) begin
                n_tests++;
                if ({street_a, street_b} !== ((i == 4) ? 6'b000_000 : 6'b010_010)) begin
                    n_fail++; $display("FAIL flash_toggle_%0d got a=%b b=%b", i, street_a, street_b);
                end
            end
        end
    endtask

    task automatic test_flash_exit();
        int n = 0;
        flash_mode = 1'b0;
        @(negedge clk);
        n_tests++;
        if ({street_a, street_b, remain_a, phase_start} !== {3'b010, 3'b100, 6'd1, 1'b1}) begin
            n_fail++; $display("FAIL flash_exit got a=%b b=%b ra=%0d ps=%b want a=010 b=100 ra=1 ps=1",
                               street_a, street_b, remain_a, phase_start);
        end
        while (street_b !== 3'b001 && n < 100) begin
            @(negedge clk); n++;
            n_tests++;
            if (dut_vec !== exp_vec()) begin
                n_fail++; $display("FAIL flash_exit_model got=%h want=%h", dut_vec, exp_vec());
            end
        end
        n_tests++;
        if (n != 8) begin
            n_fail++; $display("FAIL clearance_len got=%0d want=8", n);
        end
    endtask

    task automatic test_reset_mid_phase();
        int n = 0;
        while (!(m_phase == 3 && !m_flash) && n < 100) begin
            @(negedge clk); n++;
            n_tests++;
            if (dut_vec !== exp_vec()) begin
                n_fail++; $display("FAIL rst_seek_model got=%h want=%h", dut_vec, exp_vec());
            end
        end
        rst_n = 1'b0;
        @(negedge clk);
        n_tests++;
        if (dut_vec !== {3'b001, 3'b100, 6'd2, 6'd4, 1'b0, 1'b0}) begin
            n_fail++; $display("FAIL mid_reset got=%h want=%h", dut_vec, {3'b001, 3'b100, 6'd2, 6'd4, 2'b00});
        end
        rst_n = 1'b1;
        @(negedge clk);
        n_tests++;
        if (phase_start !== 1'b0 || dut_vec !== exp_vec()) begin
            n_fail++; $display("FAIL post_reset got=%h want=%h", dut_vec, exp_vec());
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 800; i++) begin
            enable = ($urandom_range(7) != 0);
            if ($urandom_range(59) == 0) flash_mode = ~flash_mode;
            rst_n = ($urandom_range(299) != 0);
            @(negedge clk);
            n_tests++;
            if (dut_vec !== exp_vec()) begin
                n_fail++; $display("FAIL random_model cyc=%0d got=%h want=%h", i, dut_vec, exp_vec());
            end
            if (!m_flash) begin
                n_tests++;
                if (street_a !== 3'b100 && street_b !== 3'b100) begin
                    n_fail++; $display("FAIL random_conflict got a=%b b=%b want one red", street_a, street_b);
                end
            end
        end
        rst_n = 1'b1; enable = 1'b1; flash_mode = 1'b0;
    endtask

    initial begin
        test_reset();
        test_first_phase();
        test_normal_cycle();
        test_enable_freeze();
        test_flash_on_expiry();
        test_flash_exit();
        test_reset_mid_phase();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog timeout got=running want=finished");
        $fatal(1, "watchdog");
    end

endmodule
